// File: rtl/rob_dual_commit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rob_dual_commit: reorder buffer, two in-order commits/cycle, operand     |
// | bypass, self-flush on misprediction.              Rev 1.0                |
// +--------------------------------------------------------------------------+
module rob_dual_commit #(
    parameter int DEPTH    = 16,
    parameter int WB_PORTS = 2,
    localparam int IW      = $clog2(DEPTH)
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   rdy_in,
    input  logic                   flush_in,
    input  logic                   alloc_valid,
    output logic                   alloc_ready,
    output logic [IW-1:0]          alloc_id,
    input  logic                   alloc_done,
    input  logic [1:0]             alloc_type,
    input  logic [4:0]             alloc_dest,
    input  logic [31:0]            alloc_value,
    input  logic [31:0]            alloc_next_pc,
    input  logic [31:0]            alloc_target,
    input  logic                   alloc_pred,
    input  logic [WB_PORTS-1:0]    wb_valid,
    input  logic [WB_PORTS*IW-1:0] wb_id,
    input  logic [WB_PORTS*32-1:0] wb_data,
    input  logic [WB_PORTS-1:0]    wb_is_target,
    input  logic [IW-1:0]          lk_id_a,
    input  logic [IW-1:0]          lk_id_b,
    output logic                   lk_ready_a,
    output logic                   lk_ready_b,
    output logic [31:0]            lk_data_a,
    output logic [31:0]            lk_data_b,
    output logic                   cm0_en,
    output logic                   cm1_en,
    output logic [4:0]             cm0_rd,
    output logic [4:0]             cm1_rd,
    output logic [31:0]            cm0_data,
    output logic [31:0]            cm1_data,
    output logic [IW-1:0]          cm0_id,
    output logic [IW-1:0]          cm1_id,
    output logic [IW-1:0]          head_id,
    output logic                   rob_empty,
    output logic [IW:0]            count,
    output logic                   flush_out,
    output logic [31:0]            redirect_pc
);

    localparam logic [1:0] c_TYPE_OTHER  = 2'b00;
    localparam logic [1:0] c_TYPE_REG    = 2'b01;
    localparam logic [1:0] c_TYPE_BRANCH = 2'b10;
    localparam logic [1:0] c_TYPE_JALR   = 2'b11;
    localparam logic [IW:0] c_DEPTH      = (IW+1)'(DEPTH);

    logic [DEPTH-1:0] r_valid_q, r_valid_d, r_done_q, r_done_d, r_pred_q, r_pred_d;
    logic [1:0]       r_type_q    [DEPTH];
    logic [1:0]       r_type_d    [DEPTH];
    logic [4:0]       r_dest_q    [DEPTH];
    logic [4:0]       r_dest_d    [DEPTH];
    logic [31:0]      r_value_q   [DEPTH];
    logic [31:0]      r_value_d   [DEPTH];
    logic [31:0]      r_next_pc_q [DEPTH];
    logic [31:0]      r_next_pc_d [DEPTH];
    logic [31:0]      r_target_q  [DEPTH];
    logic [31:0]      r_target_d  [DEPTH];
    logic [IW-1:0]    r_head_q, r_head_d, r_tail_q, r_tail_d;
    logic [IW:0]      r_count_q, r_count_d;
    logic             r_flush_q, r_flush_d;
    logic [31:0]      r_redirect_pc_q, r_redirect_pc_d;

    logic [IW-1:0] w_h1, w_last;
    logic          w_c0, w_c1, w_commit0, w_commit1, w_alloc_fire;
    logic          w_redirect;
    logic [31:0]   w_redirect_pc;

    // Slot 1 may only follow an entry that cannot redirect fetch.
    assign w_h1         = r_head_q + 1'b1;
    assign w_c0         = r_valid_q[r_head_q] && r_done_q[r_head_q];
    assign w_c1         = w_c0 && (r_type_q[r_head_q] == c_TYPE_OTHER || r_type_q[r_head_q] == c_TYPE_REG)
                          && r_valid_q[w_h1] && r_done_q[w_h1];
    assign w_commit0    = w_c0 && rdy_in;
    assign w_commit1    = w_c1 && rdy_in;
    assign w_last       = w_c1 ? w_h1 : r_head_q;
    assign w_alloc_fire = alloc_valid && alloc_ready && rdy_in;

    assign alloc_ready = r_count_q < c_DEPTH;
    assign alloc_id    = r_tail_q;
    assign head_id     = r_head_q;
    assign rob_empty   = (r_count_q == '0);
    assign count       = r_count_q;
    assign flush_out   = r_flush_q;
    assign redirect_pc = r_redirect_pc_q;

    assign cm0_en   = w_commit0 && (r_type_q[r_head_q] == c_TYPE_REG || r_type_q[r_head_q] == c_TYPE_JALR);
    assign cm1_en   = w_commit1 && (r_type_q[w_h1] == c_TYPE_REG || r_type_q[w_h1] == c_TYPE_JALR);
    assign cm0_rd   = cm0_en ? r_dest_q[r_head_q] : 5'd0;
    assign cm1_rd   = cm1_en ? r_dest_q[w_h1] : 5'd0;
    assign cm0_data = r_value_q[r_head_q];
    assign cm1_data = r_value_q[w_h1];
    assign cm0_id   = r_head_q;
    assign cm1_id   = w_h1;

    always_comb begin
        w_redirect    = 1'b0;
        w_redirect_pc = r_target_q[w_last];
        if (w_commit0) begin
            if (r_type_q[w_last] == c_TYPE_JALR) begin
                w_redirect = 1'b1;
            end else if (r_type_q[w_last] == c_TYPE_BRANCH && r_pred_q[w_last] != r_value_q[w_last][0]) begin
                w_redirect    = 1'b1;
                w_redirect_pc = r_value_q[w_last][0] ? r_target_q[w_last] : r_next_pc_q[w_last];
            end
        end
    end

    // Later sources override earlier ones: stored entry, writeback channels, same-cycle allocation.
    function automatic logic [32:0] f_lookup(input logic [IW-1:0] id);
        logic [32:0] res;
        res = {r_done_q[id], r_value_q[id]};
        for (int i = 0; i < WB_PORTS; i++) begin
            if (wb_valid[i] && !wb_is_target[i] && wb_id[i*IW +: IW] == id) begin
                res = {1'b1, wb_data[i*32 +: 32]};
            end
        end
        if (w_alloc_fire && alloc_done && r_tail_q == id) begin
            res = {1'b1, alloc_value};
        end
        return res;
    endfunction

    always_comb begin
        {lk_ready_a, lk_data_a} = f_lookup(lk_id_a);
        {lk_ready_b, lk_data_b} = f_lookup(lk_id_b);
    end

    always_comb begin
        r_valid_d       = r_valid_q;
        r_done_d        = r_done_q;
        r_pred_d        = r_pred_q;
        r_type_d        = r_type_q;
        r_dest_d        = r_dest_q;
        r_value_d       = r_value_q;
        r_next_pc_d     = r_next_pc_q;
        r_target_d      = r_target_q;
        r_head_d        = r_head_q;
        r_tail_d        = r_tail_q;
        r_count_d       = r_count_q;
        r_flush_d       = r_flush_q;
        r_redirect_pc_d = r_redirect_pc_q;
        if (rdy_in) begin
            if (flush_in) begin
                r_valid_d = '0;
                r_head_d  = '0;
                r_tail_d  = '0;
                r_count_d = '0;
                r_flush_d = 1'b0;
            end else begin
                if (w_alloc_fire) begin
                    r_valid_d[r_tail_q]   = 1'b1;
                    r_done_d[r_tail_q]    = alloc_done;
                    r_pred_d[r_tail_q]    = alloc_pred;
                    r_type_d[r_tail_q]    = alloc_type;
                    r_dest_d[r_tail_q]    = alloc_dest;
                    r_value_d[r_tail_q]   = alloc_value;
                    r_next_pc_d[r_tail_q] = alloc_next_pc;
                    r_target_d[r_tail_q]  = alloc_target;
                    r_tail_d              = r_tail_q + 1'b1;
                end
                for (int i = 0; i < WB_PORTS; i++) begin
                    if (wb_valid[i]) begin
                        r_done_d[wb_id[i*IW +: IW]] = 1'b1;
                        if (wb_is_target[i]) begin
                            r_target_d[wb_id[i*IW +: IW]] = wb_data[i*32 +: 32];
                        end else begin
                            r_value_d[wb_id[i*IW +: IW]] = wb_data[i*32 +: 32];
                        end
                    end
                end
                if (w_commit0) begin
                    r_valid_d[r_head_q] = 1'b0;
                end
                if (w_commit1) begin
                    r_valid_d[w_h1] = 1'b0;
                end
                r_head_d  = r_head_q + IW'(w_commit0) + IW'(w_commit1);
                r_count_d = r_count_q + (IW+1)'(w_alloc_fire) - (IW+1)'(w_commit0) - (IW+1)'(w_commit1);
                r_flush_d = w_redirect;
                if (w_redirect) begin
                    r_redirect_pc_d = w_redirect_pc;
                    r_valid_d       = '0;
                    r_head_d        = '0;
                    r_tail_d        = '0;
                    r_count_d       = '0;
                end
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_valid_q       <= '0;
            r_done_q        <= '0;
            r_head_q        <= '0;
            r_tail_q        <= '0;
            r_count_q       <= '0;
            r_flush_q       <= 1'b0;
            r_redirect_pc_q <= '0;
        end else begin
            r_valid_q       <= r_valid_d;
            r_done_q        <= r_done_d;
            r_head_q        <= r_head_d;
            r_tail_q        <= r_tail_d;
            r_count_q       <= r_count_d;
            r_flush_q       <= r_flush_d;
            r_redirect_pc_q <= r_redirect_pc_d;
        end
    end

    always_ff @(posedge clk_in) begin
        r_pred_q    <= r_pred_d;
        r_type_q    <= r_type_d;
        r_dest_q    <= r_dest_d;
        r_value_q   <= r_value_d;
        r_next_pc_q <= r_next_pc_d;
        r_target_q  <= r_target_d;
    end

endmodule
`default_nettype wire

// File: tb/tb_rob_dual_commit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_rob_dual_commit: directed stimulus with a commit/redirect scoreboard. |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_rob_dual_commit;

    localparam int DEPTH    = 16;
    localparam int WB_PORTS = 2;
    localparam int IW       = $clog2(DEPTH);
    localparam logic [1:0] c_OTHER  = 2'b00;
    localparam logic [1:0] c_REG    = 2'b01;
    localparam logic [1:0] c_BRANCH = 2'b10;
    localparam logic [1:0] c_JALR   = 2'b11;

    logic                   clk, rst_in, rdy_in, flush_in;
    logic                   alloc_valid, alloc_ready, alloc_done, alloc_pred;
    logic [IW-1:0]          alloc_id;
    logic [1:0]             alloc_type;
    logic [4:0]             alloc_dest;
    logic [31:0]            alloc_value, alloc_next_pc, alloc_target;
    logic [WB_PORTS-1:0]    wb_valid, wb_is_target;
    logic [WB_PORTS*IW-1:0] wb_id;
    logic [WB_PORTS*32-1:0] wb_data;
    logic [IW-1:0]          lk_id_a, lk_id_b;
    logic                   lk_ready_a, lk_ready_b;
    logic [31:0]            lk_data_a, lk_data_b;
    logic                   cm0_en, cm1_en;
    logic [4:0]             cm0_rd, cm1_rd;
    logic [31:0]            cm0_data, cm1_data;
    logic [IW-1:0]          cm0_id, cm1_id, head_id;
    logic                   rob_empty, flush_out;
    logic [IW:0]            count;
    logic [31:0]            redirect_pc;

    rob_dual_commit #(.DEPTH(DEPTH), .WB_PORTS(WB_PORTS)) dut (
        .clk_in(clk), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_id(alloc_id),
        .alloc_done(alloc_done), .alloc_type(alloc_type), .alloc_dest(alloc_dest),
        .alloc_value(alloc_value), .alloc_next_pc(alloc_next_pc), .alloc_target(alloc_target),
        .alloc_pred(alloc_pred), .wb_valid(wb_valid), .wb_id(wb_id), .wb_data(wb_data),
        .wb_is_target(wb_is_target), .lk_id_a(lk_id_a), .lk_id_b(lk_id_b),
        .lk_ready_a(lk_ready_a), .lk_ready_b(lk_ready_b), .lk_data_a(lk_data_a),
        .lk_data_b(lk_data_b), .cm0_en(cm0_en), .cm1_en(cm1_en), .cm0_rd(cm0_rd),
        .cm1_rd(cm1_rd), .cm0_data(cm0_data), .cm1_data(cm1_data), .cm0_id(cm0_id),
        .cm1_id(cm1_id), .head_id(head_id), .rob_empty(rob_empty), .count(count),
        .flush_out(flush_out), .redirect_pc(redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic          slot;
        logic [4:0]    rd;
        logic [31:0]   data;
        logic [IW-1:0] id;
    } cm_t;

    cm_t         exp_cm[$];
    logic [31:0] exp_rd[$];
    int          checks   = 0;
    int          failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_cm(input logic s, input logic [4:0] rd, input logic [31:0] d, input logic [IW-1:0] id);
        cm_t e;
        e.slot = s; e.rd = rd; e.data = d; e.id = id;
        exp_cm.push_back(e);
    endtask

    task automatic mon_commit(input logic s, input logic [4:0] rd, input logic [31:0] d, input logic [IW-1:0] id);
        cm_t e;
        if (exp_cm.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_commit: slot %0d id %0d rd %0d data %h, none expected", s, id, rd, d);
        end else begin
            e = exp_cm.pop_front();
            chk("commit_slot", 32'(s), 32'(e.slot));
            chk("commit_rd", 32'(rd), 32'(e.rd));
            chk("commit_data", d, e.data);
            chk("commit_id", 32'(id), 32'(e.id));
        end
    endtask

    always @(negedge clk) begin
        if (!rst_in) begin
            if (cm0_en) mon_commit(1'b0, cm0_rd, cm0_data, cm0_id);
            if (cm1_en) mon_commit(1'b1, cm1_rd, cm1_data, cm1_id);
            if (flush_out) begin
                if (exp_rd.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_flush: redirect_pc %h, none expected", redirect_pc);
                end else begin
                    chk("redirect_pc_mon", redirect_pc, exp_rd.pop_front());
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        alloc_valid = 1'b0; alloc_done = 1'b0; alloc_type = c_OTHER; alloc_dest = '0;
        alloc_value = '0; alloc_next_pc = '0; alloc_target = '0; alloc_pred = 1'b0;
        wb_valid = '0; wb_is_target = '0; wb_id = '0; wb_data = '0;
        flush_in = 1'b0; rdy_in = 1'b1;
    endtask

    task automatic set_alloc(input logic [1:0] t, input logic d, input logic [4:0] rd,
                             input logic [31:0] v, input logic [31:0] npc, input logic [31:0] tgt, input logic p);
        alloc_valid = 1'b1; alloc_type = t; alloc_done = d; alloc_dest = rd;
        alloc_value = v; alloc_next_pc = npc; alloc_target = tgt; alloc_pred = p;
    endtask

    task automatic set_wb(input int ch, input logic [IW-1:0] id, input logic [31:0] d, input logic tgt);
        wb_valid[ch] = 1'b1;
        wb_is_target[ch] = tgt;
        wb_id[ch*IW +: IW] = id;
        wb_data[ch*32 +: 32] = d;
    endtask

    initial begin
        clr();
        lk_id_a = '0; lk_id_b = '0;
        rst_in = 1'b1;
        repeat (2) step();
        rst_in = 1'b0;
        chk("rst_empty", 32'(rob_empty), 1);
        chk("rst_count", 32'(count), 0);
        chk("rst_alloc_ready", 32'(alloc_ready), 1);
        chk("rst_flush_out", 32'(flush_out), 0);
        chk("rst_redirect_pc", redirect_pc, 0);
        chk("rst_head_id", 32'(head_id), 0);
        chk("rst_cm0_en", 32'(cm0_en), 0);
        chk("rst_cm0_rd", 32'(cm0_rd), 0);

        // Fill to capacity, then a refused 17th allocation.
        for (int k = 0; k < DEPTH; k++) begin
            set_alloc(c_REG, 1'b0, 5'(k + 1), 32'h0, 32'h0, 32'h0, 1'b0);
            step();
        end
        chk("full_count", 32'(count), 16);
        chk("full_alloc_ready", 32'(alloc_ready), 0);
        chk("full_tail_wrap", 32'(alloc_id), 0);
        step();
        chk("full_ignored", 32'(count), 16);
        clr();
        set_wb(0, 4'd1, 32'h11, 1'b0);
        step();
        clr();
        chk("wb1_no_commit", 32'(count), 16);
        push_cm(1'b0, 5'd1, 32'h10, 4'd0);
        push_cm(1'b1, 5'd2, 32'h11, 4'd1);
        set_wb(0, 4'd0, 32'h10, 1'b0);
        step();
        clr();
        step();
        chk("dual_count", 32'(count), 14);
        chk("dual_head", 32'(head_id), 2);
        for (int p = 0; p < 7; p++) begin
            push_cm(1'b0, 5'(3 + 2 * p), 32'h102 + 32'(2 * p), 4'(2 + 2 * p));
            push_cm(1'b1, 5'(4 + 2 * p), 32'h103 + 32'(2 * p), 4'(3 + 2 * p));
            set_wb(0, 4'(2 + 2 * p), 32'h102 + 32'(2 * p), 1'b0);
            set_wb(1, 4'(3 + 2 * p), 32'h103 + 32'(2 * p), 1'b0);
            step();
        end
        clr();
        step();
        chk("drain_empty", 32'(rob_empty), 1);
        chk("drain_head_wrap", 32'(head_id), 0);

        // Operand lookup bypass.
        for (int k = 0; k < 4; k++) begin
            set_alloc(c_REG, 1'b0, 5'(20 + k), 32'h0, 32'h0, 32'h0, 1'b0);
            step();
        end
        clr();
        lk_id_a = 4'd3; lk_id_b = 4'd2;
        set_wb(0, 4'd3, 32'hBEEF, 1'b0);
        set_wb(1, 4'd3, 32'hDEAD, 1'b0);
        #1;
        chk("byp_wb_ready", 32'(lk_ready_a), 1);
        chk("byp_wb_data", lk_data_a, 32'hDEAD);
        chk("byp_not_done", 32'(lk_ready_b), 0);
        step();
        clr();
        chk("byp_stored_ready", 32'(lk_ready_a), 1);
        chk("byp_stored_data", lk_data_a, 32'hDEAD);
        set_alloc(c_REG, 1'b1, 5'd24, 32'h4444, 32'h0, 32'h0, 1'b0);
        lk_id_a = 4'd4;
        #1;
        chk("byp_alloc_ready", 32'(lk_ready_a), 1);
        chk("byp_alloc_data", lk_data_a, 32'h4444);
        step();
        clr();
        push_cm(1'b0, 5'd20, 32'hA0, 4'd0);
        push_cm(1'b1, 5'd21, 32'hA1, 4'd1);
        set_wb(0, 4'd0, 32'hA0, 1'b0);
        set_wb(1, 4'd1, 32'hA1, 1'b0);
        step();
        clr();
        push_cm(1'b0, 5'd22, 32'hA2, 4'd2);
        push_cm(1'b1, 5'd23, 32'hDEAD, 4'd3);
        push_cm(1'b0, 5'd24, 32'h4444, 4'd4);
        set_wb(0, 4'd2, 32'hA2, 1'b0);
        step();
        clr();
        repeat (2) step();
        chk("byp_drain_count", 32'(count), 0);
        chk("byp_drain_head", 32'(head_id), 5);

        // Branch at head blocks slot 1.
        set_alloc(c_BRANCH, 1'b0, 5'd0, 32'h0, 32'h40, 32'h80, 1'b0);
        step();
        set_alloc(c_REG, 1'b1, 5'd9, 32'h99, 32'h0, 32'h0, 1'b0);
        step();
        clr();
        set_wb(0, 4'd5, 32'h0, 1'b0);
        step();
        clr();
        chk("brh_cm0_en", 32'(cm0_en), 0);
        chk("brh_cm1_en", 32'(cm1_en), 0);
        push_cm(1'b0, 5'd9, 32'h99, 4'd6);
        step();
        chk("brh_single_count", 32'(count), 1);
        chk("brh_single_head", 32'(head_id), 6);
        step();
        chk("brh_done_count", 32'(count), 0);

        // JALR committing in slot 1 redirects fetch.
        set_alloc(c_REG, 1'b0, 5'd10, 32'h0, 32'h0, 32'h0, 1'b0);
        step();
        set_alloc(c_JALR, 1'b1, 5'd1, 32'h804, 32'h0, 32'h2000, 1'b0);
        step();
        clr();
        push_cm(1'b0, 5'd10, 32'h77, 4'd7);
        push_cm(1'b1, 5'd1, 32'h804, 4'd8);
        exp_rd.push_back(32'h2000);
        set_wb(0, 4'd7, 32'h77, 1'b0);
        step();
        clr();
        chk("jalr_cm1_en", 32'(cm1_en), 1);
        step();
        chk("jalr_flush", 32'(flush_out), 1);
        chk("jalr_redirect", redirect_pc, 32'h2000);
        chk("jalr_count", 32'(count), 0);
        chk("jalr_head", 32'(head_id), 0);
        step();
        chk("jalr_flush_pulse", 32'(flush_out), 0);

        // Taken mispredict; same-cycle allocation must be dropped.
        set_alloc(c_BRANCH, 1'b0, 5'd0, 32'h0, 32'h44, 32'h100, 1'b0);
        step();
        clr();
        set_wb(0, 4'd0, 32'h1, 1'b0);
        step();
        clr();
        exp_rd.push_back(32'h100);
        set_alloc(c_REG, 1'b1, 5'd3, 32'h33, 32'h0, 32'h0, 1'b0);
        step();
        clr();
        chk("mp_flush", 32'(flush_out), 1);
        chk("mp_redirect", redirect_pc, 32'h100);
        chk("mp_count", 32'(count), 0);
        chk("mp_alloc_id", 32'(alloc_id), 0);
        step();
        chk("mp_flush_pulse", 32'(flush_out), 0);
        step();

        // Not-taken mispredict, then flush_out held across a stall.
        set_alloc(c_BRANCH, 1'b0, 5'd0, 32'h0, 32'h48, 32'h900, 1'b1);
        step();
        clr();
        set_wb(0, 4'd0, 32'h0, 1'b0);
        step();
        clr();
        exp_rd.push_back(32'h48);
        step();
        chk("nt_redirect", redirect_pc, 32'h48);
        exp_rd.push_back(32'h48);
        rdy_in = 1'b0;
        step();
        chk("nt_flush_hold", 32'(flush_out), 1);
        rdy_in = 1'b1;
        step();
        chk("nt_flush_clear", 32'(flush_out), 0);

        // JALR whose target arrives on a target writeback.
        set_alloc(c_JALR, 1'b0, 5'd1, 32'h5004, 32'h0, 32'h0, 1'b0);
        step();
        clr();
        push_cm(1'b0, 5'd1, 32'h5004, 4'd0);
        exp_rd.push_back(32'h3000);
        set_wb(1, 4'd0, 32'h3000, 1'b1);
        step();
        clr();
        step();
        chk("wbt_redirect", redirect_pc, 32'h3000);
        step();

        // Stall: nothing moves while rdy_in is low.
        set_alloc(c_REG, 1'b0, 5'd11, 32'h0, 32'h0, 32'h0, 1'b0);
        step();
        set_alloc(c_REG, 1'b0, 5'd12, 32'h0, 32'h0, 32'h0, 1'b0);
        step();
        clr();
        set_wb(0, 4'd0, 32'hC0, 1'b0);
        set_wb(1, 4'd1, 32'hC1, 1'b0);
        step();
        clr();
        rdy_in = 1'b0;
        set_alloc(c_REG, 1'b1, 5'd13, 32'hEE, 32'h0, 32'h0, 1'b0);
        set_wb(0, 4'd0, 32'hBAD0, 1'b0);
        set_wb(1, 4'd1, 32'hBAD1, 1'b0);
        #1;
        for (int k = 0; k < 5; k++) begin
            chk("stall_cm0_en", 32'(cm0_en), 0);
            chk("stall_cm1_en", 32'(cm1_en), 0);
            step();
        end
        chk("stall_count", 32'(count), 2);
        chk("stall_head", 32'(head_id), 0);
        chk("stall_tail", 32'(alloc_id), 2);
        push_cm(1'b0, 5'd11, 32'hC0, 4'd0);
        push_cm(1'b1, 5'd12, 32'hC1, 4'd1);
        clr();
        step();
        chk("stall_release_count", 32'(count), 0);

        // External flush beats allocation and writeback.
        set_alloc(c_REG, 1'b0, 5'd14, 32'h0, 32'h0, 32'h0, 1'b0);
        step();
        set_alloc(c_REG, 1'b1, 5'd15, 32'h15, 32'h0, 32'h0, 1'b0);
        step();
        clr();
        flush_in = 1'b1;
        set_alloc(c_REG, 1'b1, 5'd16, 32'h16, 32'h0, 32'h0, 1'b0);
        set_wb(0, 4'd2, 32'h22, 1'b0);
        step();
        clr();
        chk("xfl_count", 32'(count), 0);
        chk("xfl_flush_out", 32'(flush_out), 0);
        chk("xfl_head", 32'(head_id), 0);
        chk("xfl_tail", 32'(alloc_id), 0);
        repeat (2) step();

        // Reset in mid-operation.
        set_alloc(c_REG, 1'b0, 5'd17, 32'h0, 32'h0, 32'h0, 1'b0);
        step();
        chk("mid_count_pre", 32'(count), 1);
        rst_in = 1'b1;
        step();
        rst_in = 1'b0;
        clr();
        chk("mid_rst_count", 32'(count), 0);
        chk("mid_rst_tail", 32'(alloc_id), 0);
        chk("mid_rst_empty", 32'(rob_empty), 1);

        repeat (3) step();
        chk("sb_commits_left", 32'(exp_cm.size()), 0);
        chk("sb_redirects_left", 32'(exp_rd.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
